dcache_responder: RTL and testbench
===================================

# dcache_responder

Direct-mapped, write-back data cache controller that answers the load/store requests issued by the decode/memory pipeline. It owns tag, valid, dirty and data arrays, reports `cache_hit`/`cache_dirty` back to the controller, and runs the writeback and refill sequences against main memory over a word-serial req/ack handshake. It sits between the pipeline's memory stage and the main memory model, and stalls the PC and pipeline while a miss is serviced.

## Interface
- `LINES`, 16: number of cache lines (power of two, ≥2).
- `WORDS`, 4: 32-bit words per line (power of two, ≥2).

- `clk`  in  1  rising-edge clock.
- `rst_b`  in  1  synchronous, active-high reset (asserted = 1).
- `req_valid`  in  1  pipeline request present.
- `req_we`  in  1  1 = store, 0 = load.
- `req_is_word`  in  1  1 = word access, 0 = byte access.
- `req_addr`  in  32  byte address; the word offset is `[1:0]` when `req_is_word`=0, and is ignored otherwise.
- `req_wdata`  in  32  store data; byte stores use `[7:0]`.
- `resp_valid`  out  1  one-cycle pulse when a request completes.
- `resp_rdata`  out  32  load data; byte loads are zero-extended.
- `cache_hit`  out  1  lookup result for the request currently in LOOKUP.
- `cache_dirty`  out  1  dirty bit of the indexed line during LOOKUP.
- `stall`  out  1  holds the pipeline and deasserts `pc_enable` upstream.
- `mem_req`  out  1  memory beat request.
- `mem_we`  out  1  beat is a write.
- `mem_addr`  out  32  word-aligned beat address.
- `mem_wdata`  out  32  writeback beat data.
- `mem_ack`  in  1  beat accepted or completed; `mem_rdata` is valid in the same cycle.
- `mem_rdata`  in  32  refill beat data.

## Operation
- Address split: offset `[1:0]`, word `[2+log2 WORDS-1:2]`, index `[next log2 LINES bits]`, tag = remaining upper bits.
- FSM states: IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND.
- IDLE: when `req_valid`=1, latch the request and go to LOOKUP. `stall`=1 from the accept cycle until the `resp_valid` cycle inclusive.
- LOOKUP: hit = valid && tag match.
  - On a hit: a load reads the word/byte; a store merges the byte/word, then sets dirty and valid. Go to RESPOND.
  - On a miss with valid && dirty: go to WRITEBACK.
  - Otherwise: go to REFILL.
- WRITEBACK: issue WORDS beats of `mem_req`=1, `mem_we`=1, word 0 first, using the old tag's address. A beat advances only on `mem_ack`. After the last ack, clear dirty and go to REFILL.
- REFILL: issue WORDS read beats, word 0 first, writing `mem_rdata` into the line on each `mem_ack`. After the last beat, set the tag, set valid, clear dirty, and return to LOOKUP. This guarantees a hit.
- RESPOND: `resp_valid`=1 for one cycle, then go to IDLE. The following request is accepted no earlier than the next cycle.
- `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are held stable until `mem_ack`.
- Byte store: the write mask selects lane `req_addr[1:0]`; the other lanes are unchanged.
- Byte load: `resp_rdata` = {24'b0, selected byte}.
- `req_*` inputs are ignored outside IDLE.

## Timing
- Reset values: all outputs 0, FSM = IDLE, all valid and dirty bits 0. The data and tag arrays are not reset.
- Hit latency: accept at cycle N, LOOKUP at N+1, `resp_valid` at N+2.
- Clean miss: N+2 + (WORDS beats × memory wait) + 2.
- Dirty miss: adds WORDS writeback beats before the refill.
- A zero-wait memory (ack in the same cycle as req) gives one beat per cycle.
- `cache_hit` and `cache_dirty` are valid only in LOOKUP cycles and are 0 elsewhere.
- Reset asserted mid-WRITEBACK or mid-REFILL:
  - The FSM returns to IDLE next cycle and `mem_req` drops.
  - All lines are invalidated and the partial transfer is discarded.
  - Memory may hold a partially written-back line; this is acceptable.
- `mem_ack` without `mem_req` is ignored.

## Configuration
- `DCACHE_STATS_EN` defined:
  - Adds 32-bit output counters `stat_hits`, `stat_misses` and `stat_writebacks`.
  - Each counter increments once per first-LOOKUP hit, once per first-LOOKUP miss, and once per completed writeback respectively.
  - The LOOKUP after a refill is not counted.
  - Counters reset to 0 and wrap at 2^32.
- Undefined: the counters and their ports are absent; behaviour is otherwise identical.

## Test plan
- Reset, then load word at 0x40 with a zero-wait memory returning 0x11,0x22,0x33,0x44 -> 4 read beats at 0x40–0x4C, then `resp_rdata`=0x11 and `resp_valid` 8 cycles after accept.
- Repeat the load of 0x44 -> `cache_hit`=1, `resp_rdata`=0x22, `resp_valid` at accept+2, no `mem_req`.
- Byte store 0xAB to 0x46, then byte load of 0x46 -> `resp_rdata`=0x000000AB. A word load of 0x44 returns 0x00AB0022 (was 0x22), and the line is dirty.
- Load 0x40 + LINES×WORDS×4 (same index, new tag) -> `cache_dirty`=1 in LOOKUP; 4 write beats at 0x40.. with the modified data, then 4 refill beats, then the response.
- Memory acks after 3 wait cycles -> `mem_addr` and `mem_wdata` stay stable across the waits, and the beat count stays exactly WORDS.
- Assert `rst_b` during the second refill beat -> next cycle is IDLE, `mem_req`=0, `stall`=0; a reload of the same address misses.

Source files
------------

// File: rtl/dcache_responder_if.sv
// Pipeline request/response and word-serial memory bus for dcache_responder.
// slave = the cache controller, master = pipeline memory stage plus main memory.
interface dcache_responder_if;
    logic        req_valid;
    logic        req_we;
    logic        req_is_word;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        cache_hit;
    logic        cache_dirty;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output req_valid, req_we, req_is_word, req_addr, req_wdata, mem_ack, mem_rdata,
        input  resp_valid, resp_rdata, cache_hit, cache_dirty, stall,
               mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, req_we, req_is_word, req_addr, req_wdata, mem_ack, mem_rdata,
        output resp_valid, resp_rdata, cache_hit, cache_dirty, stall,
               mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dcache_responder.sv
// Direct-mapped write-back data cache controller with word-serial writeback/refill.
// Define DCACHE_STATS_EN to add hit/miss/writeback counters.
module dcache_responder #(
    parameter int LINES = 16,
    parameter int WORDS = 4
) (
    input  logic              clk,
    input  logic              rst_b,
    dcache_responder_if.slave bus
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]       stat_hits,
    output logic [31:0]       stat_misses,
    output logic [31:0]       stat_writebacks
`endif
);
    localparam int OFF_W = $clog2(WORDS);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 30 - OFF_W - IDX_W;

    typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND} state_t;

    state_t           state;
    logic             r_we, r_is_word, refilled;
    logic [31:0]      r_addr, r_wdata;
    logic [OFF_W-1:0] beat, nxt_beat;
    logic [31:0]      data_q [LINES][WORDS];
    logic [TAG_W-1:0] tag_q [LINES];
    logic [LINES-1:0] valid_q, dirty_q;

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [OFF_W-1:0] woff;
    logic [1:0]       boff;
    logic             hit, last_beat;
    logic [31:0]      cur_word, st_word, ld_word;

    assign idx       = r_addr[2+OFF_W +: IDX_W];
    assign tag       = r_addr[31 -: TAG_W];
    assign woff      = r_addr[2 +: OFF_W];
    assign boff      = r_addr[1:0];
    assign hit       = valid_q[idx] && (tag_q[idx] == tag);
    assign nxt_beat  = beat + 1'b1;
    assign last_beat = (beat == OFF_W'(WORDS - 1));
    assign cur_word  = data_q[idx][woff];
    assign ld_word   = r_is_word ? cur_word : {24'b0, cur_word[8*boff +: 8]};

    // Byte stores replace only the addressed lane; word stores replace all four.
    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign st_word[8*i +: 8] = r_is_word          ? r_wdata[8*i +: 8] :
                                   (boff == 2'(i))    ? r_wdata[7:0]      : cur_word[8*i +: 8];
    end

    assign bus.cache_hit   = (state == LOOKUP) && hit;
    assign bus.cache_dirty = (state == LOOKUP) && dirty_q[idx];
    assign bus.stall       = (state != IDLE) || bus.req_valid;

    always_ff @(posedge clk) begin
        if (rst_b) begin
            state         <= IDLE;
            valid_q       <= '0;
            dirty_q       <= '0;
            r_we          <= 1'b0;
            r_is_word     <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            beat          <= '0;
            refilled      <= 1'b0;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= '0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
`ifdef DCACHE_STATS_EN
            stat_hits       <= '0;
            stat_misses     <= '0;
            stat_writebacks <= '0;
`endif
        end else begin
            bus.resp_valid <= 1'b0;
            case (state)
                IDLE: if (bus.req_valid) begin
                    r_we      <= bus.req_we;
                    r_is_word <= bus.req_is_word;
                    r_addr    <= bus.req_addr;
                    r_wdata   <= bus.req_wdata;
                    refilled  <= 1'b0;
                    state     <= LOOKUP;
                end
                LOOKUP: if (hit) begin
                    if (r_we) begin
                        data_q[idx][woff] <= st_word;
                        dirty_q[idx]      <= 1'b1;
                        valid_q[idx]      <= 1'b1;
                    end else begin
                        bus.resp_rdata <= ld_word;
                    end
                    bus.resp_valid <= 1'b1;
                    state          <= RESPOND;
`ifdef DCACHE_STATS_EN
                    if (!refilled) stat_hits <= stat_hits + 1'b1;
`endif
                end else begin
                    beat  <= '0;
                    state <= (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : REFILL;
`ifdef DCACHE_STATS_EN
                    stat_misses <= stat_misses + 1'b1;
`endif
                end
                WRITEBACK: if (!bus.mem_req) begin
                    bus.mem_req   <= 1'b1;
                    bus.mem_we    <= 1'b1;
                    bus.mem_addr  <= {tag_q[idx], idx, {OFF_W{1'b0}}, 2'b00};
                    bus.mem_wdata <= data_q[idx][0];
                end else if (bus.mem_ack) begin
                    if (last_beat) begin
                        // Chain straight into the first refill beat, keeping mem_req high.
                        dirty_q[idx] <= 1'b0;
                        beat         <= '0;
                        bus.mem_we   <= 1'b0;
                        bus.mem_addr <= {tag, idx, {OFF_W{1'b0}}, 2'b00};
                        state        <= REFILL;
`ifdef DCACHE_STATS_EN
                        stat_writebacks <= stat_writebacks + 1'b1;
`endif
                    end else begin
                        beat          <= nxt_beat;
                        bus.mem_addr  <= {tag_q[idx], idx, nxt_beat, 2'b00};
                        bus.mem_wdata <= data_q[idx][nxt_beat];
                    end
                end
                REFILL: if (!bus.mem_req) begin
                    bus.mem_req  <= 1'b1;
                    bus.mem_we   <= 1'b0;
                    bus.mem_addr <= {tag, idx, {OFF_W{1'b0}}, 2'b00};
                end else if (bus.mem_ack) begin
                    data_q[idx][beat] <= bus.mem_rdata;
                    if (last_beat) begin
                        bus.mem_req  <= 1'b0;
                        tag_q[idx]   <= tag;
                        valid_q[idx] <= 1'b1;
                        dirty_q[idx] <= 1'b0;
                        refilled     <= 1'b1;
                        beat         <= '0;
                        state        <= LOOKUP;
                    end else begin
                        beat         <= nxt_beat;
                        bus.mem_addr <= {tag, idx, nxt_beat, 2'b00};
                    end
                end
                RESPOND: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_responder.sv
// Directed + randomized bench for dcache_responder against a flat-memory/residency model.
module tb_dcache_responder;
    localparam int L = 16;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst_b = 1'b1;
    always #5 clk = ~clk;

    dcache_responder_if bus();

`ifdef DCACHE_STATS_EN
    logic [31:0] stat_hits, stat_misses, stat_writebacks;
`endif

    dcache_responder #(.LINES(L), .WORDS(W)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
`ifdef DCACHE_STATS_EN
        ,
        .stat_hits       (stat_hits),
        .stat_misses     (stat_misses),
        .stat_writebacks (stat_writebacks)
`endif
    );

    // Main memory: initial pattern plus an overlay of written words.
    function automatic logic [31:0] init_word(input int i);
        if (i >= 16 && i < 20) return 32'(32'h11 * (i - 15));
        return 32'hC0DE_0000 ^ 32'(i * 32'h9E37);
    endfunction

    logic [31:0] mem_wr [1024];
    bit          mem_vld [1024];
    int          mem_wait = 0;
    int          wcnt = 0;

    assign bus.mem_ack   = bus.mem_req && (wcnt == mem_wait);
    assign bus.mem_rdata = mem_vld[bus.mem_addr[11:2]] ? mem_wr[bus.mem_addr[11:2]]
                                                       : init_word(int'(bus.mem_addr[11:2]));

    typedef struct packed { logic we; logic [31:0] addr; logic [31:0] data; } beat_t;
    beat_t beats[$];
    int          stab_err = 0;
    logic        pend = 1'b0;
    logic [65:0] pend_val = '0;

    always @(posedge clk) begin
        if (bus.mem_req && bus.mem_ack) begin
            beats.push_back(beat_t'({bus.mem_we, bus.mem_addr,
                                     bus.mem_we ? bus.mem_wdata : bus.mem_rdata}));
            if (bus.mem_we) begin
                mem_wr[bus.mem_addr[11:2]]  <= bus.mem_wdata;
                mem_vld[bus.mem_addr[11:2]] <= 1'b1;
            end
        end
        wcnt <= (bus.mem_req && !bus.mem_ack) ? wcnt + 1 : 0;
    end

    // A beat waiting for ack must hold its request fields unchanged.
    always @(negedge clk) begin
        if (pend && ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== pend_val))
            stab_err <= stab_err + 1;
        pend     <= bus.mem_req && !bus.mem_ack && !rst_b;
        pend_val <= {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata};
    end

    // Reference: coherent word view of memory plus which tag each index holds.
    logic [31:0] ref_words [1024];
    int          res_tag [L];
    bit          res_dirty [L];
    int          exp_hits = 0, exp_misses = 0, exp_wbs = 0;
    int          tests = 0, fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        tests++;
        assert (obs === want) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 1024; i++) ref_words[i] = mem_vld[i] ? mem_wr[i] : init_word(i);
        for (int i = 0; i < L; i++) begin
            res_tag[i]   = -1;
            res_dirty[i] = 1'b0;
        end
        exp_hits = 0; exp_misses = 0; exp_wbs = 0;
    endtask

    task automatic txn(input logic we, input logic iw, input logic [31:0] addr,
                       input logic [31:0] wd, output logic [31:0] rd, output int lat);
        int idx, tg, wi, nb, want_lat;
        bit want_hit, want_dirty;
        logic got_hit, got_dirty;
        logic [31:0] want_rd, a;
        beat_t eb[$];
        idx = int'(addr[7:4]);
        tg  = int'(addr[11:8]);
        wi  = int'(addr[11:2]);
        want_hit   = (res_tag[idx] == tg);
        want_dirty = res_dirty[idx];
        if (!want_hit) begin
            if (want_dirty)
                for (int k = 0; k < W; k++) begin
                    a = 32'((res_tag[idx] << 8) | (idx << 4) | (k << 2));
                    eb.push_back(beat_t'({1'b1, a, ref_words[a[11:2]]}));
                end
            for (int k = 0; k < W; k++) begin
                a = (addr & 32'hFFFF_FFF0) + 32'(k * 4);
                eb.push_back(beat_t'({1'b0, a, ref_words[a[11:2]]}));
            end
        end
        nb       = eb.size();
        want_lat = want_hit ? 2 : 4 + nb * (mem_wait + 1);
        want_rd  = iw ? ref_words[wi] : ((ref_words[wi] >> (8 * addr[1:0])) & 32'hFF);
        if (want_hit) exp_hits++;
        else begin
            exp_misses++;
            if (want_dirty) exp_wbs++;
            res_dirty[idx] = 1'b0;
        end
        res_tag[idx] = tg;
        if (we) begin
            if (iw) ref_words[wi] = wd;
            else    ref_words[wi][8*addr[1:0] +: 8] = wd[7:0];
            res_dirty[idx] = 1'b1;
        end

        beats.delete();
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_is_word = iw;
        bus.req_addr = addr;  bus.req_wdata = wd;
        #1 check("stall_accept", 32'(bus.stall), 32'd1);
        @(negedge clk);
        got_hit   = bus.cache_hit;
        got_dirty = bus.cache_dirty;
        bus.req_valid = 1'b0; bus.req_we = 1'($urandom);
        bus.req_addr = $urandom; bus.req_wdata = $urandom;
        lat = 1;
        while (!bus.resp_valid && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        rd = bus.resp_rdata;
        check("resp_valid", 32'(bus.resp_valid), 32'd1);
        check("lookup_hit", 32'(got_hit), 32'(want_hit));
        check("lookup_dirty", 32'(got_dirty), 32'(want_dirty));
        check("latency", 32'(lat), 32'(want_lat));
        check("stall_resp", 32'(bus.stall), 32'd1);
        check("hit_outside_lookup", 32'(bus.cache_hit), 32'd0);
        if (!we) check("rdata", rd, want_rd);
        check("beat_count", 32'(beats.size()), 32'(nb));
        for (int k = 0; k < nb && k < beats.size(); k++) begin
            check("beat_we", 32'(beats[k].we), 32'(eb[k].we));
            check("beat_addr", beats[k].addr, eb[k].addr);
            check("beat_data", beats[k].data, eb[k].data);
        end
        @(negedge clk);
        check("resp_pulse_end", 32'(bus.resp_valid), 32'd0);
        check("stall_release", 32'(bus.stall), 32'd0);
        check("mem_req_idle", 32'(bus.mem_req), 32'd0);
    endtask

    initial begin
        logic [31:0] rd, a;
        int lat, cyc;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_is_word = 1'b0;
        bus.req_addr = '0; bus.req_wdata = '0;
        model_reset();
        rst_b = 1'b1;
        repeat (3) @(negedge clk);
        rst_b = 1'b0;
        @(negedge clk);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_resp_rdata", bus.resp_rdata, 32'd0);
        check("rst_stall", 32'(bus.stall), 32'd0);
        check("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_cache_hit", 32'(bus.cache_hit), 32'd0);
        check("rst_cache_dirty", 32'(bus.cache_dirty), 32'd0);

        // Cold miss, hit, byte store/load, merged word.
        txn(1'b0, 1'b1, 32'h40, 32'h0, rd, lat);
        check("tp_load40", rd, 32'h11);
        check("tp_load40_lat", 32'(lat), 32'd8);
        txn(1'b0, 1'b1, 32'h44, 32'h0, rd, lat);
        check("tp_load44", rd, 32'h22);
        check("tp_load44_lat", 32'(lat), 32'd2);
        txn(1'b1, 1'b0, 32'h46, 32'h1234_56AB, rd, lat);
        txn(1'b0, 1'b0, 32'h46, 32'h0, rd, lat);
        check("tp_byte46", rd, 32'h0000_00AB);
        txn(1'b0, 1'b1, 32'h44, 32'h0, rd, lat);
        check("tp_word44", rd, 32'h00AB_0022);

        // Conflicting tag on a dirty line: writeback then refill.
        txn(1'b0, 1'b1, 32'h40 + L * W * 4, 32'h0, rd, lat);
        check("tp_wb_beats", 32'(beats.size()), 32'd8);
        check("tp_wb_beat1_addr", beats[1].addr, 32'h44);
        check("tp_wb_beat1_data", beats[1].data, 32'h00AB_0022);
        check("tp_wb_lat", 32'(lat), 32'd12);

        // Slow memory: three wait cycles per beat.
        mem_wait = 3;
        txn(1'b1, 1'b1, 32'h140, 32'hDEAD_BEEF, rd, lat);
        txn(1'b0, 1'b1, 32'h40, 32'h0, rd, lat);
        check("tp_slow_rdata", rd, 32'h11);
        check("tp_slow_beats", 32'(beats.size()), 32'd8);
        check("tp_slow_lat", 32'(lat), 32'd36);
        check("tp_slow_stable", 32'(stab_err), 32'd0);

        // Reset during the second refill beat.
        mem_wait = 0;
        beats.delete();
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_is_word = 1'b1; bus.req_addr = 32'h80;
        @(negedge clk);
        bus.req_valid = 1'b0;
        cyc = 0;
        while (!(beats.size() == 1 && bus.mem_req) && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("rst_mid_reach_beat2", 32'(beats.size()), 32'd1);
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        check("rst_mid_mem_req", 32'(bus.mem_req), 32'd0);
        check("rst_mid_stall", 32'(bus.stall), 32'd0);
        check("rst_mid_resp", 32'(bus.resp_valid), 32'd0);
        model_reset();
        txn(1'b0, 1'b1, 32'h80, 32'h0, rd, lat);
        check("rst_reload_lat", 32'(lat), 32'd8);

        // Randomized traffic over a few tags and indices to mix hits, clean and dirty misses.
        for (int n = 0; n < 60; n++) begin
            a = 32'(($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 4) | $urandom_range(0, 15));
            mem_wait = $urandom_range(0, 2);
            txn(1'($urandom), 1'($urandom), a, $urandom, rd, lat);
        end
        check("final_stable", 32'(stab_err), 32'd0);

`ifdef DCACHE_STATS_EN
        check("stat_hits", stat_hits, 32'(exp_hits));
        check("stat_misses", stat_misses, 32'(exp_misses));
        check("stat_writebacks", stat_writebacks, 32'(exp_wbs));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
